// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stage enable/clear sequencer with halt FSM; define PIPE_HAZARD_STATS_EN for perf counters
module pipe_hazard_ctrl #(
    parameter int REG_W = 5
`ifdef PIPE_HAZARD_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             in_CLK,
    input  logic             in_CLR_N,
    input  logic             in_ex_memread,
    input  logic [REG_W-1:0] in_ex_rd,
    input  logic [REG_W-1:0] in_id_rs,
    input  logic [REG_W-1:0] in_id_rt,
    input  logic             in_id_use_rs,
    input  logic             in_id_use_rt,
    input  logic             in_branch_taken,
    input  logic             in_mem_wait,
    input  logic             in_halt,
    input  logic             in_go,
    output logic             out_pc_en,
    output logic             out_ifid_en,
    output logic             out_idex_en,
    output logic             out_exmem_en,
    output logic             out_memwb_en,
    output logic             out_ifid_clr,
    output logic             out_idex_clr,
    output logic             out_exmem_clr,
    output logic             out_memwb_clr,
    output logic             out_halted
`ifdef PIPE_HAZARD_STATS_EN
    , output logic [CNT_W-1:0] out_cyc_cnt
    , output logic [CNT_W-1:0] out_stall_cnt
    , output logic [CNT_W-1:0] out_flush_cnt
`endif
);
    typedef enum logic [1:0] {RUN, HALT, RESUME} state_t;
    state_t state_q, state_d;
    logic   halted_q;
    logic   lu;
    assign lu = in_ex_memread & (in_ex_rd != '0) &
                ((in_id_use_rs & (in_id_rs == in_ex_rd)) | (in_id_use_rt & (in_id_rt == in_ex_rd)));
    assign out_halted = halted_q;
    // Mealy stage control and next state; reset forces every stage cleared and frozen
    always_comb begin
        out_pc_en     = 1'b1;
        out_ifid_en   = 1'b1;
        out_idex_en   = 1'b1;
        out_exmem_en  = 1'b1;
        out_memwb_en  = 1'b1;
        out_ifid_clr  = 1'b0;
        out_idex_clr  = 1'b0;
        out_exmem_clr = 1'b0;
        out_memwb_clr = 1'b0;
        state_d       = state_q;
        if (!in_CLR_N) begin
            {out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en} = '0;
            {out_ifid_clr, out_idex_clr, out_exmem_clr, out_memwb_clr} = '1;
            state_d = RUN;
        end else if (state_q == HALT) begin
            {out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en} = '0;
            state_d = in_go ? RESUME : HALT;
        end else if (in_mem_wait) begin
            {out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en} = '0;
        end else if (in_halt && state_q == RUN) begin
            {out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en} = '0;
            state_d = HALT;
        end else begin
            state_d = RUN;
            if (in_branch_taken) begin
                out_ifid_clr = 1'b1;
                out_idex_clr = 1'b1;
            end else if (lu) begin
                out_pc_en    = 1'b0;
                out_ifid_en  = 1'b0;
                out_idex_clr = 1'b1;
            end
        end
    end
    // State register; halted flag registered alongside so it is glitch-free
    always_ff @(posedge in_CLK) begin
        if (!in_CLR_N) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
        end
    end
`ifdef PIPE_HAZARD_STATS_EN
    logic [CNT_W-1:0] cyc_q, stall_q, flush_q;
    logic             stall_ev, flush_ev;
    assign stall_ev = (state_q != HALT && in_mem_wait) || (out_idex_clr && !out_pc_en);
    assign flush_ev = out_ifid_clr && out_pc_en;
    assign out_cyc_cnt   = cyc_q;
    assign out_stall_cnt = stall_q;
    assign out_flush_cnt = flush_q;
    // Free-running wrap-around performance counters
    always_ff @(posedge in_CLK) begin
        if (!in_CLR_N) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            cyc_q   <= cyc_q + CNT_W'(state_q != HALT);
            stall_q <= stall_q + CNT_W'(stall_ev);
            flush_q <= flush_q + CNT_W'(flush_ev);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam logic [8:0] C_RUN = 9'b11111_0000;
    localparam logic [8:0] C_FRZ = 9'b00000_0000;
    localparam logic [8:0] C_BR  = 9'b11111_1100;
    localparam logic [8:0] C_LU  = 9'b00111_0100;
    localparam logic [8:0] C_RST = 9'b00000_1111;
    logic       in_CLK = 1'b0;
    logic       in_CLR_N = 1'b0;
    logic       in_ex_memread = 1'b0;
    logic [4:0] in_ex_rd = '0;
    logic [4:0] in_id_rs = '0;
    logic [4:0] in_id_rt = '0;
    logic       in_id_use_rs = 1'b0;
    logic       in_id_use_rt = 1'b0;
    logic       in_branch_taken = 1'b0;
    logic       in_mem_wait = 1'b0;
    logic       in_halt = 1'b0;
    logic       in_go = 1'b0;
    logic       out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en;
    logic       out_ifid_clr, out_idex_clr, out_exmem_clr, out_memwb_clr;
    logic       out_halted;
    logic [8:0] ctl;
    int         errors = 0;
    int         checks = 0;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] out_cyc_cnt, out_stall_cnt, out_flush_cnt;
    logic [31:0] s0, f0, c0;
`endif
    assign ctl = {out_pc_en, out_ifid_en, out_idex_en, out_exmem_en, out_memwb_en,
                  out_ifid_clr, out_idex_clr, out_exmem_clr, out_memwb_clr};
    pipe_hazard_ctrl dut (
        .in_CLK(in_CLK), .in_CLR_N(in_CLR_N), .in_ex_memread(in_ex_memread),
        .in_ex_rd(in_ex_rd), .in_id_rs(in_id_rs), .in_id_rt(in_id_rt),
        .in_id_use_rs(in_id_use_rs), .in_id_use_rt(in_id_use_rt),
        .in_branch_taken(in_branch_taken), .in_mem_wait(in_mem_wait),
        .in_halt(in_halt), .in_go(in_go),
        .out_pc_en(out_pc_en), .out_ifid_en(out_ifid_en), .out_idex_en(out_idex_en),
        .out_exmem_en(out_exmem_en), .out_memwb_en(out_memwb_en),
        .out_ifid_clr(out_ifid_clr), .out_idex_clr(out_idex_clr),
        .out_exmem_clr(out_exmem_clr), .out_memwb_clr(out_memwb_clr),
        .out_halted(out_halted)
`ifdef PIPE_HAZARD_STATS_EN
        , .out_cyc_cnt(out_cyc_cnt), .out_stall_cnt(out_stall_cnt), .out_flush_cnt(out_flush_cnt)
`endif
    );
    always #5 in_CLK = ~in_CLK;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge in_CLK);
        #1;
    endtask
    task automatic idle();
        in_ex_memread = 0; in_ex_rd = 0; in_id_rs = 0; in_id_rt = 0;
        in_id_use_rs = 0; in_id_use_rt = 0; in_branch_taken = 0;
        in_mem_wait = 0; in_halt = 0; in_go = 0;
    endtask
    initial begin
        @(negedge in_CLK);
        check("reset_ctl", ctl, C_RST);
        tick();
        check("reset_halted", out_halted, 0);
`ifdef PIPE_HAZARD_STATS_EN
        check("reset_cyc", out_cyc_cnt, 0);
`endif
        in_CLR_N = 1;
        @(negedge in_CLK);
        check("idle_ctl", ctl, C_RUN);
        tick();
        // load-use on rs
        in_ex_memread = 1; in_ex_rd = 5; in_id_rs = 5; in_id_use_rs = 1;
`ifdef PIPE_HAZARD_STATS_EN
        s0 = out_stall_cnt;
`endif
        @(negedge in_CLK);
        check("lu_rs_ctl", ctl, C_LU);
        tick();
`ifdef PIPE_HAZARD_STATS_EN
        check("lu_stall_cnt", out_stall_cnt, s0 + 1);
`endif
        // r0 never a hazard
        in_ex_rd = 0; in_id_rs = 0;
        @(negedge in_CLK);
        check("lu_r0_ctl", ctl, C_RUN);
        tick();
        // load-use on rt, then rt not used
        in_ex_rd = 7; in_id_rs = 3; in_id_rt = 7; in_id_use_rs = 1; in_id_use_rt = 1;
        @(negedge in_CLK);
        check("lu_rt_ctl", ctl, C_LU);
        tick();
        in_id_use_rt = 0;
        @(negedge in_CLK);
        check("lu_rt_unused_ctl", ctl, C_RUN);
        tick();
        // branch + load-use: branch wins
        in_id_use_rt = 1; in_branch_taken = 1;
`ifdef PIPE_HAZARD_STATS_EN
        s0 = out_stall_cnt; f0 = out_flush_cnt;
`endif
        @(negedge in_CLK);
        check("br_lu_ctl", ctl, C_BR);
        tick();
`ifdef PIPE_HAZARD_STATS_EN
        check("br_flush_cnt", out_flush_cnt, f0 + 1);
        check("br_stall_cnt", out_stall_cnt, s0);
`endif
        // halt, hold 3 cycles with hazards asserted, then go
        idle();
        in_halt = 1;
        @(negedge in_CLK);
        check("halt_req_ctl", ctl, C_FRZ);
        check("halt_req_halted", out_halted, 0);
        tick();
        in_branch_taken = 1; in_mem_wait = 1;
`ifdef PIPE_HAZARD_STATS_EN
        c0 = out_cyc_cnt; s0 = out_stall_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge in_CLK);
            check("halt_hold_ctl", ctl, C_FRZ);
            check("halt_hold_halted", out_halted, 1);
            tick();
        end
`ifdef PIPE_HAZARD_STATS_EN
        check("halt_cyc_cnt", out_cyc_cnt, c0);
        check("halt_stall_cnt", out_stall_cnt, s0);
`endif
        in_branch_taken = 0; in_mem_wait = 0; in_go = 1;
        @(negedge in_CLK);
        check("halt_go_ctl", ctl, C_FRZ);
        tick();
        in_go = 0;
        @(negedge in_CLK);
        check("resume_ctl", ctl, C_RUN);
        check("resume_halted", out_halted, 0);
        tick();
        in_halt = 0;
        @(negedge in_CLK);
        check("run_after_resume_ctl", ctl, C_RUN);
        check("run_after_resume_halted", out_halted, 0);
        tick();
        // mem_wait 4 cycles over a taken branch
        in_mem_wait = 1; in_branch_taken = 1;
`ifdef PIPE_HAZARD_STATS_EN
        s0 = out_stall_cnt; f0 = out_flush_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge in_CLK);
            check("memwait_ctl", ctl, C_FRZ);
            tick();
        end
        in_mem_wait = 0;
        @(negedge in_CLK);
        check("memwait_release_ctl", ctl, C_BR);
        tick();
`ifdef PIPE_HAZARD_STATS_EN
        check("memwait_stall_cnt", out_stall_cnt, s0 + 4);
        check("memwait_flush_cnt", out_flush_cnt, f0 + 1);
`endif
        // mem_wait during RESUME keeps RESUME (halt still ignored)
        idle();
        in_halt = 1;
        tick();
        in_go = 1;
        tick();
        in_go = 0; in_mem_wait = 1;
        @(negedge in_CLK);
        check("resume_wait_ctl", ctl, C_FRZ);
        tick();
        in_mem_wait = 0;
        @(negedge in_CLK);
        check("resume_held_ctl", ctl, C_RUN);
        check("resume_held_halted", out_halted, 0);
        tick();
        @(negedge in_CLK);
        check("rehalt_in_run_ctl", ctl, C_FRZ);
        tick();
        check("rehalt_halted", out_halted, 1);
        // reset while halted
        in_CLR_N = 0; in_branch_taken = 1;
        @(negedge in_CLK);
        check("reset_in_halt_ctl", ctl, C_RST);
        tick();
        check("reset_in_halt_halted", out_halted, 0);
`ifdef PIPE_HAZARD_STATS_EN
        check("reset_stall_cnt", out_stall_cnt, 0);
        check("reset_flush_cnt", out_flush_cnt, 0);
`endif
        in_CLR_N = 1; in_halt = 0;
        @(negedge in_CLK);
        check("post_reset_run_ctl", ctl, C_BR);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
